// File: rtl/serial_signmag_addsub_if.sv
// serial_signmag_addsub_if
// Handshake and data bundle for the bit-serial sign-magnitude add/subtract unit.
//   in_valid / in_ready     operand handshake (source -> unit)
//   a_mag, a_neg            operand A magnitude and negative flag
//   b_mag, b_neg            operand B magnitude and negative flag
//   M                       0 = A+B, 1 = A-B
//   out_valid / out_ready   result handshake (unit -> consumer)
//   s_mag, s_neg, ovf       result magnitude, negative flag, add-path carry out
// master: operand source / result consumer side. slave: the unit itself.
interface serial_signmag_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_mag;
    logic             a_neg;
    logic [WIDTH-1:0] b_mag;
    logic             b_neg;
    logic             M;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s_mag;
    logic             s_neg;
    logic             ovf;

    modport master (
        output in_valid, a_mag, a_neg, b_mag, b_neg, M, out_ready,
        input  in_ready, out_valid, s_mag, s_neg, ovf
    );

    modport slave (
        input  in_valid, a_mag, a_neg, b_mag, b_neg, M, out_ready,
        output in_ready, out_valid, s_mag, s_neg, ovf
    );
endinterface

// File: rtl/serial_signmag_addsub.sv
// serial_signmag_addsub
// Bit-serial add/subtract of sign-magnitude operands, one bit per clock, LSB
// first. An effective subtraction that borrows takes a second serial pass to
// negate the two's-complement intermediate back into a magnitude.
// Ports:
//   clk   clock, all state changes on rising edge
//   rst   synchronous active-high reset
//   bus   serial_signmag_addsub_if.slave (operand and result handshakes)
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand set
// CALC  | serial add of A and B (B inverted, carry-in 1 on subtract)
// FIX   | serial two's-complement negate of the borrowed result
// DONE  | out_valid=1, result held until out_ready
module serial_signmag_addsub #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_signmag_addsub_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             c;
    logic             sub_q;
    logic             a_neg_q;

    logic             eff_sub;
    logic             last;
    logic             calc_bit;
    logic             calc_c;
    logic             fix_bit;
    logic             fix_c;
    logic [WIDTH-1:0] calc_r;
    logic [WIDTH-1:0] fix_r;
    logic [WIDTH-1:0] fin_mag;
    logic             fin_ovf;
    logic             fin_neg;

    assign bus.in_ready = (state == IDLE) && !rst;

    // Signs differ once B's sign is flipped by M -> magnitudes subtract.
    assign eff_sub = bus.a_neg ^ bus.b_neg ^ bus.M;
    assign last    = (cnt == CW'(WIDTH - 1));

    assign calc_bit = a_sh[0] ^ b_sh[0] ^ c;
    assign calc_c   = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
    assign fix_bit  = ~r_sh[0] ^ c;
    assign fix_c    = ~r_sh[0] & c;

    // Result bits enter at the MSB so the word is in place after WIDTH shifts.
    assign calc_r = {calc_bit, r_sh[WIDTH-1:1]};
    assign fix_r  = {fix_bit,  r_sh[WIDTH-1:1]};

    // Final result values, used only on the edge that enters DONE.
    always_comb begin
        fin_mag = calc_r;
        fin_ovf = ~sub_q & calc_c;
        fin_neg = a_neg_q;
        if (state == FIX) begin
            fin_mag = fix_r;
            fin_ovf = 1'b0;
            fin_neg = ~a_neg_q;
        end
        // No negative zero; an overflowed zero magnitude still carries its sign.
        if ((fin_mag == '0) && !fin_ovf)
            fin_neg = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            c             <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.s_mag     <= '0;
            bus.s_neg     <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh    <= bus.a_mag;
                        b_sh    <= eff_sub ? ~bus.b_mag : bus.b_mag;
                        c       <= eff_sub;
                        sub_q   <= eff_sub;
                        a_neg_q <= bus.a_neg;
                        cnt     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= calc_r;
                    c    <= calc_c;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        if (sub_q && !calc_c) begin
                            // Borrow: B > A, intermediate is A-B+2^WIDTH.
                            cnt   <= '0;
                            c     <= 1'b1;
                            state <= FIX;
                        end else begin
                            bus.s_mag     <= fin_mag;
                            bus.s_neg     <= fin_neg;
                            bus.ovf       <= fin_ovf;
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                FIX: begin
                    r_sh <= fix_r;
                    c    <= fix_c;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        bus.s_mag     <= fin_mag;
                        bus.s_neg     <= fin_neg;
                        bus.ovf       <= fin_ovf;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_signmag_addsub.sv
// tb_serial_signmag_addsub
// Directed cases plus randomized operand sets for serial_signmag_addsub,
// checked against a signed-integer reference model.
module tb_serial_signmag_addsub;
    localparam int W = 16;

    logic clk;
    logic rst;

    serial_signmag_addsub_if #(.WIDTH(W)) bus ();

    serial_signmag_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] obs_mag;
    logic         obs_neg;
    logic         obs_ovf;
    int           obs_lat;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain signed arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic an,
                         input logic [W-1:0] b, input logic bn, input logic m,
                         output logic [W-1:0] emag, output logic eneg,
                         output logic eovf, output int elat);
        longint va, vb, vr, av;
        va = an ? -longint'(a) : longint'(a);
        vb = bn ? -longint'(b) : longint'(b);
        vr = m ? (va - vb) : (va + vb);
        av = (vr < 0) ? -vr : vr;
        eovf = (av >= (longint'(1) << W));
        emag = W'(av);
        eneg = (vr < 0);
        // A second pass happens when the result's sign is opposite to A's flag.
        elat = ((vr != 0) && ((vr < 0) != an)) ? 2 * W : W;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic an,
                          input logic [W-1:0] b, input logic bn, input logic m,
                          input int stall);
        int  t;
        logic busy_ok;
        bus.a_mag     = a;
        bus.a_neg     = an;
        bus.b_mag     = b;
        bus.b_neg     = bn;
        bus.M         = m;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.a_mag    = W'($urandom);
        bus.b_mag    = W'($urandom);
        bus.M        = 1'($urandom);
        obs_lat = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && obs_lat < 3 * W) begin
            if (bus.in_ready) busy_ok = 1'b0;
            tick();
            obs_lat++;
        end
        chk("busy_in_ready_low", busy_ok, 1);
        if (!bus.out_valid) chk("result_timeout", 0, 1);
        obs_mag = bus.s_mag;
        obs_neg = bus.s_neg;
        obs_ovf = bus.ovf;
        for (int k = 0; k < stall; k++) begin
            bus.in_valid = 1'($urandom);
            bus.a_mag    = W'($urandom);
            bus.b_mag    = W'($urandom);
            tick();
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_s_mag", bus.s_mag, obs_mag);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("release_out_valid", bus.out_valid, 0);
        chk("release_in_ready", bus.in_ready, 1);
        chk("hold_s_mag", bus.s_mag, obs_mag);
    endtask

    task automatic run_checked(input logic [W-1:0] a, input logic an,
                               input logic [W-1:0] b, input logic bn,
                               input logic m, input int stall);
        logic [W-1:0] emag;
        logic         eneg, eovf;
        int           elat;
        model(a, an, b, bn, m, emag, eneg, eovf, elat);
        run_op(a, an, b, bn, m, stall);
        chk("mag", obs_mag, emag);
        chk("neg", obs_neg, eneg);
        chk("ovf", obs_ovf, eovf);
        chk("latency", obs_lat, elat);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int t;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_mag     = '0;
        bus.a_neg     = 1'b0;
        bus.b_mag     = '0;
        bus.b_neg     = 1'b0;
        bus.M         = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_s_mag", bus.s_mag, 0);
        chk("reset_s_neg", bus.s_neg, 0);
        chk("reset_ovf", bus.ovf, 0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", bus.in_ready, 1);

        run_op(16'd100, 1'b0, 16'd200, 1'b0, 1'b0, 0);
        chk("add_mag", obs_mag, 300);
        chk("add_neg", obs_neg, 0);
        chk("add_ovf", obs_ovf, 0);
        chk("add_lat", obs_lat, 16);

        run_op(16'd5, 1'b0, 16'd9, 1'b0, 1'b1, 0);
        chk("borrow_mag", obs_mag, 4);
        chk("borrow_neg", obs_neg, 1);
        chk("borrow_ovf", obs_ovf, 0);
        chk("borrow_lat", obs_lat, 32);

        run_op(16'hFFFF, 1'b0, 16'd1, 1'b0, 1'b0, 0);
        chk("ovf_mag", obs_mag, 0);
        chk("ovf_ovf", obs_ovf, 1);
        chk("ovf_neg", obs_neg, 0);

        run_op(16'd10, 1'b1, 16'd3, 1'b1, 1'b1, 0);
        chk("negsub_mag", obs_mag, 7);
        chk("negsub_neg", obs_neg, 1);
        chk("negsub_lat", obs_lat, 16);

        run_op(16'd7, 1'b1, 16'd7, 1'b0, 1'b0, 0);
        chk("zero_mag", obs_mag, 0);
        chk("zero_neg", obs_neg, 0);

        run_op(16'd1, 1'b0, 16'd1, 1'b0, 1'b0, 5);
        chk("bp_mag", obs_mag, 2);
        run_checked(16'd1234, 1'b1, 16'd34, 1'b0, 1'b0, 0);

        // Reset during FIX: accept, then rst sampled on edge 20.
        bus.a_mag    = 16'd5;
        bus.a_neg    = 1'b0;
        bus.b_mag    = 16'd9;
        bus.b_neg    = 1'b0;
        bus.M        = 1'b1;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_s_mag", bus.s_mag, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        run_op(16'd3, 1'b0, 16'd4, 1'b0, 1'b0, 0);
        chk("after_abort_mag", obs_mag, 7);
        chk("after_abort_lat", obs_lat, 16);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = W'($urandom); rb = W'($urandom); end
                1: begin ra = W'($urandom); rb = ra; end
                2: begin ra = W'($urandom_range(0, 7)); rb = W'($urandom_range(0, 7)); end
                default: begin
                    ra = W'(16'hFFFF - W'($urandom_range(0, 3)));
                    rb = W'($urandom_range(0, 3));
                end
            endcase
            run_checked(ra, 1'($urandom), rb, 1'($urandom), 1'($urandom),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_signmag_addsub.md
Name: serial_signmag_addsub

Overview:
- Bit-serial add/subtract unit for operands in sign-magnitude form: a magnitude plus a negative flag.
- Consumes the same magnitude-plus-flag format the combinational adder/subtractor produces, so its results can be fed back in or chained.
- Processes one bit per clock, LSB first. When an effective subtraction borrows, a second serial pass forms the two's-complement correction.
- Valid/ready handshake on input and output; sits in the datapath between the operand source and the result consumer.

Parameters:
WIDTH, 16, magnitude width of operands and result

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand set present
in_ready  output  1  unit can accept operands
a_mag  input  WIDTH  operand A magnitude
a_neg  input  1  operand A negative flag
b_mag  input  WIDTH  operand B magnitude
b_neg  input  1  operand B negative flag
M  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result present
out_ready  input  1  consumer takes result
s_mag  output  WIDTH  result magnitude
s_neg  output  1  result negative flag
ovf  output  1  magnitude overflow (carry out of add path)

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high. While rst is sampled high: state=IDLE, bit counter=0, out_valid=0, s_mag=0, s_neg=0, ovf=0, and inputs are ignored. in_ready is combinational (state==IDLE && !rst): 0 during reset, 1 in the first cycle after.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. When in_valid && in_ready at an edge:
  - latch the operands;
  - compute the effective B sign eb = b_neg ^ M;
  - op = ADD if a_neg==eb, else SUB;
  - carry init = 0 for ADD, 1 for SUB (B bits inverted on SUB);
  - go to CALC with counter=0.
- CALC: one bit per edge, LSB first.
  - r[i] = a[i] ^ b'[i] ^ c; c updated with the full-adder carry; counter increments.
  - After the edge that processes bit WIDTH-1, final carry cf:
    - ADD: ovf=cf, s_neg=a_neg → DONE.
    - SUB with cf=1 (A≥B): ovf=0, s_neg=a_neg → DONE.
    - SUB with cf=0 (borrow): → FIX, counter=0, carry=1.
- FIX: WIDTH edges. r[i] = ~r[i] ^ c, c = ~r[i] & c (serial two's-complement negate). Then s_neg=~a_neg, ovf=0 → DONE.
- Zero rule: on entry to DONE, if s_mag==0 and ovf==0 then force s_neg=0. There is never a negative zero out; negative-zero inputs behave as zero.
- DONE: out_valid=1. s_mag, s_neg and ovf are stable and in_ready=0 until out_valid && out_ready at an edge. Then go to IDLE with out_valid=0. s_mag, s_neg and ovf keep their value until the next result is written.
- Latency, counted from the accepting edge:
  - out_valid high after WIDTH edges (no FIX);
  - 2*WIDTH edges with FIX.
- Throughput: no accept in the same cycle as output handshake, so minimum spacing is WIDTH+2 cycles.
- ADD-path ovf=1 means the true magnitude is 2^WIDTH + s_mag. The sign is still a_neg, and the zero rule does not apply when ovf=1.
- in_valid is ignored outside IDLE. Operand inputs may change after acceptance without effect.
- rst mid-CALC/FIX/DONE aborts the operation. The partial result is discarded and the unit is ready the following cycle.

Test Plan:
- Add (WIDTH=16): a=+100, b=+200, M=0 → s_mag=300, s_neg=0, ovf=0; out_valid exactly 16 cycles after accept.
- Borrow correction: a=+5, b=+9, M=1 → s_mag=4, s_neg=1, ovf=0; out_valid 32 cycles after accept; in_ready low throughout.
- Overflow / mixed signs / zero:
  - a=+0xFFFF, b=+1, M=0 → s_mag=0, ovf=1, s_neg=0.
  - a=-10, b=-3, M=1 → s_mag=7, s_neg=1 (16 cycles).
  - a=-7, b=+7, M=0 → s_mag=0, s_neg=0.
- Backpressure: complete +1 + +1, hold out_ready=0 for 5 cycles while toggling in_valid with new operands → out_valid, s_mag=2 stable, in_ready=0, nothing accepted. Raise out_ready → IDLE next cycle; the next op is accepted and correct.
- Reset mid-op: start +5 - +9, assert rst for 1 cycle at cycle 20 (during FIX) → next cycle out_valid=0, s_mag=0, in_ready=1. Then +3 + +4 → s_mag=7 after 16 cycles.
- Randomized check: 1000 random operand/M/sign sets with random out_ready → every result matches a signed-integer reference model for magnitude, sign, ovf and latency.
